// File: rtl/acc_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : acc_result_drain
//  Function : MAC accumulator reader. Captures results, requantizes them to
//             OUT_W bits (round-half-up, saturating), buffers them in a FIFO
//             and streams them out over valid/ready. Define DRAIN_STATS_EN to
//             build the saturated-result counter.
//  Revision : 1.0  initial release
// ============================================================================
module acc_result_drain #(
   parameter int ACC_W      = 16,
   parameter int OUT_W      = 8,
   parameter int SHIFT      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               acc_valid,
   input  logic [ACC_W-1:0]                   acc_in,
   input  logic                               acc_ovf,
   output logic                               acc_ready,
   output logic                               acc_clear,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [OUT_W-1:0]                   out_data,
   output logic                               out_sat,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               drop_err,
   output logic [15:0]                        sat_count
);

   localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                 CNT_W     = $clog2(FIFO_DEPTH+1);
   localparam logic [ACC_W:0]     C_OUT_MAX = (ACC_W+1)'((2**OUT_W) - 1);
   localparam logic [CNT_W-1:0]   C_FULL    = CNT_W'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // Requantization (one extra bit keeps the rounding carry)
   // ---------------------------------------------------------------------
   logic [ACC_W:0]   rq_val;
   logic             rq_sat;
   logic [OUT_W-1:0] rq_data;

   generate
      if (SHIFT == 0) begin : g_no_round
         assign rq_val = {1'b0, acc_in};
      end else begin : g_round
         localparam logic [ACC_W:0] C_HALF = (ACC_W+1)'(1) << (SHIFT-1);
         logic [ACC_W:0] rq_sum;
         assign rq_sum = {1'b0, acc_in} + C_HALF;
         assign rq_val = rq_sum >> SHIFT;
      end
   endgenerate

   assign rq_sat  = acc_ovf || (rq_val > C_OUT_MAX);
   assign rq_data = rq_sat ? {OUT_W{1'b1}} : rq_val[OUT_W-1:0];

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   logic [OUT_W:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               drop_q, drop_d;
   logic               clear_q, clear_d;
   logic               push, pop;

   assign acc_ready = (count_q != C_FULL);
   assign out_valid = (count_q != '0);
   assign push      = acc_valid && acc_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      clear_d  = push;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A pop on the same edge does not free space for a blocked result.
      if (acc_valid && !acc_ready) drop_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
         clear_q  <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= {rq_sat, rq_data};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         clear_q  <= clear_d;
      end
   end

   assign {out_sat, out_data} = mem_q[rd_ptr_q];
   assign fifo_count          = count_q;
   assign drop_err            = drop_q;
   assign acc_clear           = clear_q;

   // ---------------------------------------------------------------------
   // Saturation statistics
   // ---------------------------------------------------------------------
`ifdef DRAIN_STATS_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (push && rq_sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`else
   assign sat_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acc_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_result_drain
//  Function : Randomized and directed checks of acc_result_drain against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_result_drain;

   localparam int ACC_W = 16, OUT_W = 8, SHIFT = 4, DEPTH = 4;
   localparam int MAXV  = (2**OUT_W) - 1;

   typedef struct { logic [7:0] d; logic s; } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        acc_valid = 1'b0;
   logic [15:0] acc_in = '0;
   logic        acc_ovf = 1'b0;
   logic        out_ready = 1'b0;
   logic        acc_ready, acc_clear, out_valid, out_sat, drop_err;
   logic [7:0]  out_data;
   logic [2:0]  fifo_count;
   logic [15:0] sat_count;

   int n_tests = 0;
   int n_fail  = 0;

   ent_t        mq[$];
   bit          m_drop  = 0;
   bit          m_clear = 0;
   logic [15:0] m_sat   = '0;

   acc_result_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_in(acc_in), .acc_ovf(acc_ovf),
      .acc_ready(acc_ready), .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .fifo_count(fifo_count), .drop_err(drop_err),
      .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   function automatic ent_t ref_q(input int a, input bit ovf);
      int   r;
      ent_t e;
      r = (a + (2**SHIFT) / 2) / (2**SHIFT);
      if (ovf || r > MAXV) begin e.d = 8'hFF; e.s = 1'b1; end
      else begin e.d = r[7:0]; e.s = 1'b0; end
      return e;
   endfunction

   // One clock: drive inputs, advance the model with pre-edge state, sample 1 ns after the edge.
   task automatic cycle(input bit v, input logic [15:0] d, input bit o, input bit rdy);
      bit   push, pop;
      ent_t e;
      acc_valid = v; acc_in = d; acc_ovf = o; out_ready = rdy;
      push = v && (mq.size() < DEPTH);
      pop  = rdy && (mq.size() > 0);
      e    = ref_q(int'(d), o);
      @(posedge clk); #1;
      if (pop)  mq.delete(0);
      if (push) mq.push_back(e);
      if (v && !push) m_drop = 1;
      m_clear = push;
`ifdef DRAIN_STATS_EN
      if (push && e.s && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
`endif
   endtask

   task automatic do_reset(input bit v);
      rst = 1'b1; acc_valid = v; acc_in = 16'h0123; acc_ovf = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; acc_valid = 1'b0;
      mq.delete(); m_drop = 0; m_clear = 0; m_sat = '0;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_tests++; if (acc_clear !== 1'b0) begin n_fail++; $display("FAIL reset_acc_clear got %b exp 0", acc_clear); end
      n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      n_tests++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got %b exp 0", drop_err); end
      n_tests++; if ({out_sat, out_data} !== 9'd0) begin n_fail++; $display("FAIL reset_head got %h exp 000", {out_sat, out_data}); end
      n_tests++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count got %h exp 0", sat_count); end
      n_tests++; if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_acc_ready got %b exp 1", acc_ready); end
   endtask

   // Single capture then drain; checks data against a spec constant and the model.
   task automatic push_pop_one(input string nm, input logic [15:0] d, input bit o,
                               input logic [7:0] exp_d, input bit exp_s);
      cycle(1'b1, d, o, 1'b1);
      n_tests++; if (acc_clear !== 1'b1) begin n_fail++; $display("FAIL %s_clear got %b exp 1", nm, acc_clear); end
      n_tests++; if ({out_valid, out_sat, out_data} !== {1'b1, exp_s, exp_d})
         begin n_fail++; $display("FAIL %s_head got v=%b s=%b d=%h exp v=1 s=%b d=%h", nm, out_valid, out_sat, out_data, exp_s, exp_d); end
      n_tests++; if ({out_sat, out_data} !== {mq[0].s, mq[0].d})
         begin n_fail++; $display("FAIL %s_model got %h exp %h", nm, {out_sat, out_data}, {mq[0].s, mq[0].d}); end
      n_tests++; if (sat_count !== m_sat) begin n_fail++; $display("FAIL %s_sat_count got %0d exp %0d", nm, sat_count, m_sat); end
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++; if (acc_clear !== 1'b0) begin n_fail++; $display("FAIL %s_clear_end got %b exp 0", nm, acc_clear); end
      n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL %s_count_end got %0d exp 0", nm, fifo_count); end
   endtask

   task automatic test_rounding();
      push_pop_one("round", 16'h0128, 1'b0, 8'h13, 1'b0);
      push_pop_one("round_sat", 16'h0FF8, 1'b0, 8'hFF, 1'b1);
      push_pop_one("round_255", 16'h0FF7, 1'b0, 8'hFF, 1'b0);
      push_pop_one("shift0_edge", 16'h0007, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_ovf_flag();
      push_pop_one("ovf_flag", 16'h0010, 1'b1, 8'hFF, 1'b1);
   endtask

   task automatic test_full_drop();
      logic [7:0] exp_d;
      for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i * 16), 1'b0, 1'b0);
      n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", fifo_count); end
      n_tests++; if (acc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", acc_ready); end
      cycle(1'b1, 16'h0050, 1'b0, 1'b0);
      n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b exp 1", drop_err); end
      n_tests++; if (acc_clear !== 1'b0) begin n_fail++; $display("FAIL drop_clear got %b exp 0", acc_clear); end
      n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL drop_count got %0d exp 4", fifo_count); end
      for (int i = 1; i <= 4; i++) begin
         exp_d = 8'(i);
         n_tests++; if ({out_valid, out_data} !== {1'b1, exp_d})
            begin n_fail++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d); end
         cycle(1'b0, 16'h0, 1'b0, 1'b1);
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid got %b exp 0", out_valid); end
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL underflow_count got %0d exp 0", fifo_count); end
      n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got %b exp 1", drop_err); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 16'h0050, 1'b0, 1'b0);
      n_tests++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL simul_old_head got %h exp 05", out_data); end
      cycle(1'b1, 16'h0060, 1'b0, 1'b1);
      n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL simul_count got %0d exp 1", fifo_count); end
      n_tests++; if (acc_clear !== 1'b1) begin n_fail++; $display("FAIL simul_clear got %b exp 1", acc_clear); end
      n_tests++; if (out_data !== 8'h06) begin n_fail++; $display("FAIL simul_new_head got %h exp 06", out_data); end
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 16'h0070, 1'b0, 1'b0);
      cycle(1'b1, 16'h0080, 1'b0, 1'b0);
      cycle(1'b1, 16'h0090, 1'b0, 1'b0);
      n_tests++; if ({acc_clear, fifo_count, drop_err} !== {1'b1, 3'd3, 1'b1})
         begin n_fail++; $display("FAIL pre_rst got clr=%b cnt=%0d drop=%b exp 1 3 1", acc_clear, fifo_count, drop_err); end
      do_reset(1'b1);
      n_tests++; if (acc_clear !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear got %b exp 0", acc_clear); end
      n_tests++; if ({out_valid, fifo_count, drop_err, acc_ready} !== {1'b0, 3'd0, 1'b0, 1'b1})
         begin n_fail++; $display("FAIL rst_mid_state got v=%b cnt=%0d drop=%b rdy=%b exp 0 0 0 1", out_valid, fifo_count, drop_err, acc_ready); end
   endtask

   task automatic test_random();
      logic [15:0] d;
      bit          v, o, r;
      do_reset(1'b0);
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 45);
         o = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 3))
            0:       d = 16'($urandom_range(16'h0FF0, 16'h1008));
            1:       d = 16'($urandom_range(0, 16'h0020));
            default: d = 16'($urandom);
         endcase
         cycle(v, d, o, r);
         n_tests++; if (fifo_count !== 3'(mq.size()))
            begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, fifo_count, mq.size()); end
         n_tests++; if ({out_valid, acc_ready} !== {mq.size() > 0, mq.size() < DEPTH})
            begin n_fail++; $display("FAIL rnd_flags[%0d] got v=%b r=%b exp size %0d", i, out_valid, acc_ready, mq.size()); end
         n_tests++; if ({acc_clear, drop_err} !== {m_clear, m_drop})
            begin n_fail++; $display("FAIL rnd_clr_drop[%0d] got %b%b exp %b%b", i, acc_clear, drop_err, m_clear, m_drop); end
         n_tests++; if (sat_count !== m_sat)
            begin n_fail++; $display("FAIL rnd_sat_count[%0d] got %0d exp %0d", i, sat_count, m_sat); end
         if (mq.size() > 0) begin
            n_tests++; if ({out_sat, out_data} !== {mq[0].s, mq[0].d})
               begin n_fail++; $display("FAIL rnd_head[%0d] got %h exp %h", i, {out_sat, out_data}, {mq[0].s, mq[0].d}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_ovf_flag();
      test_full_drop();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
